// File: rtl/vga_sync.sv
// ============================================================================
// Module   : vga_sync
// Brief    : VGA timing generator with pixel-rate tick, h/v counters, syncs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

    localparam logic [9:0] c_H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);

    logic                rst_sync_q;
    logic [c_TICK_W-1:0] tick_q;
    logic [c_TICK_W-1:0] tick_d;
    logic [9:0]          x_q;
    logic [9:0]          x_d;
    logic [9:0]          y_q;
    logic [9:0]          y_d;
    logic                hsync_q;
    logic                vsync_q;
    logic                video_on_q;
    logic                w_tick;
    logic                w_x_wrap;

    // Single stage keeps the release-to-first-tick latency at TICK_DIV-1 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_comb begin
        w_tick   = rst_sync_q && (tick_q == c_TICK_LAST);
        tick_d   = (tick_q == c_TICK_LAST) ? '0 : tick_q + c_TICK_ONE;
        w_x_wrap = (x_q == c_H_LAST);
        x_d      = w_x_wrap ? 10'd0 : x_q + 10'd1;
        y_d      = y_q;
        if (w_x_wrap) begin
            y_d = (y_q == c_V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Sync/blank flops load from the next counts so they stay aligned with pix_x/pix_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= '0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else if (rst_sync_q) begin
            tick_q <= tick_d;
            if (w_tick) begin
                x_q        <= x_d;
                y_q        <= y_d;
                hsync_q    <= !((x_d >= c_HS_START) && (x_d <= c_HS_END));
                vsync_q    <= !((y_d >= c_VS_START) && (y_d <= c_VS_END));
                video_on_q <= (x_d < c_H_DISP) && (y_d < c_V_DISP);
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign p_tick      = w_tick;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign frame_start = w_tick && (x_q == 10'd0) && (y_q == 10'd0);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// ============================================================================
// Module   : tb_vga_sync
// Brief    : Directed vector bench for vga_sync at default and reduced timings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync;

    localparam int c_SH_D = 8;
    localparam int c_SH_F = 2;
    localparam int c_SH_S = 3;
    localparam int c_SH_B = 2;
    localparam int c_SV_D = 4;
    localparam int c_SV_F = 1;
    localparam int c_SV_S = 2;
    localparam int c_SV_B = 1;
    localparam int c_NV   = 13;
    localparam logic [24:0] c_RST_PACK = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
        logic       fs;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       hs0, vs0, vo0, pt0, fs0;
    logic       hs1, vs1, vo1, pt1, fs1;
    logic       hs2, vs2, vo2, pt2, fs2;
    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [24:0] obs0, obs1, obs2;

    int   checks;
    int   errors;
    vec_t tbl [c_NV];

    assign obs0 = {x0, y0, hs0, vs0, vo0, pt0, fs0};
    assign obs1 = {x1, y1, hs1, vs1, vo1, pt1, fs1};
    assign obs2 = {x2, y2, hs2, vs2, vo2, pt2, fs2};

    vga_sync u_dut0 (
        .clk(clk), .rst_n(rst_n), .hsync(hs0), .vsync(vs0), .video_on(vo0),
        .p_tick(pt0), .pix_x(x0), .pix_y(y0), .frame_start(fs0)
    );

    vga_sync #(
        .H_DISPLAY(c_SH_D), .H_FRONT(c_SH_F), .H_SYNC(c_SH_S), .H_BACK(c_SH_B),
        .V_DISPLAY(c_SV_D), .V_FRONT(c_SV_F), .V_SYNC(c_SV_S), .V_BACK(c_SV_B),
        .TICK_DIV(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hsync(hs1), .vsync(vs1), .video_on(vo1),
        .p_tick(pt1), .pix_x(x1), .pix_y(y1), .frame_start(fs1)
    );

    vga_sync #(
        .H_DISPLAY(c_SH_D), .H_FRONT(c_SH_F), .H_SYNC(c_SH_S), .H_BACK(c_SH_B),
        .V_DISPLAY(c_SV_D), .V_FRONT(c_SV_F), .V_SYNC(c_SV_S), .V_BACK(c_SV_B),
        .TICK_DIV(4)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hsync(hs2), .vsync(vs2), .video_on(vo2),
        .p_tick(pt2), .pix_x(x2), .pix_y(y2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int c, input int x, input int y, input logic hs,
                                input logic vs, input logic vo, input logic pt, input logic fs);
        vec_t v;
        v.cyc = c; v.x = 10'(x); v.y = 10'(y);
        v.hs = hs; v.vs = vs; v.vo = vo; v.pt = pt; v.fs = fs;
        return v;
    endfunction

    function automatic logic [24:0] pack(input vec_t v);
        return {v.x, v.y, v.hs, v.vs, v.vo, v.pt, v.fs};
    endfunction

    // Closed-form timing: cycle index -> pixel number -> (x, y) and derived flags.
    function automatic logic [24:0] model(input int c, input int d);
        int   ht, vt, p, x, y;
        logic hs, vs, vo, pt, fs;
        ht = c_SH_D + c_SH_F + c_SH_S + c_SH_B;
        vt = c_SV_D + c_SV_F + c_SV_S + c_SV_B;
        p  = c / d;
        x  = p % ht;
        y  = (p / ht) % vt;
        pt = ((c % d) == d - 1);
        fs = pt && (x == 0) && (y == 0);
        hs = !((x >= c_SH_D + c_SH_F) && (x < c_SH_D + c_SH_F + c_SH_S));
        vs = !((y >= c_SV_D + c_SV_F) && (y < c_SV_D + c_SV_F + c_SV_S));
        vo = (x < c_SH_D) && (y < c_SV_D);
        return {x[9:0], y[9:0], hs, vs, vo, pt, fs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_phase(input int n, input string tag);
        int mism1, mism2, tog2, ptc1, ptc2, hslow0, fsc0;
        int last1, last2, bad1, bad2, nfs1, nfs2;
        logic [22:0] prev2;
        logic        prev_pt2;
        mism1 = 0; mism2 = 0; tog2 = 0; ptc1 = 0; ptc2 = 0; hslow0 = 0; fsc0 = 0;
        last1 = -1; last2 = -1; bad1 = 0; bad2 = 0; nfs1 = 0; nfs2 = 0;
        prev2 = '0; prev_pt2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < c_NV; k++) begin
                if (tbl[k].cyc == c) begin
                    chk($sformatf("%s_vec%0d_cyc%0d", tag, k, c), 32'(obs0), 32'(pack(tbl[k])));
                end
            end
            if (obs1 !== model(c, 1)) mism1++;
            if (obs2 !== model(c, 4)) mism2++;
            if (c > 0 && obs2[24:2] !== prev2 && !prev_pt2) tog2++;
            prev2    = obs2[24:2];
            prev_pt2 = pt2;
            if (pt1) ptc1++;
            if (pt2) ptc2++;
            if (c < 1600 && pt0 && !hs0) hslow0++;
            if (fs0) fsc0++;
            if (fs1) begin
                if (last1 >= 0 && c - last1 != 120) bad1++;
                last1 = c; nfs1++;
            end
            if (fs2) begin
                if (last2 >= 0 && c - last2 != 480) bad2++;
                last2 = c; nfs2++;
            end
        end
        chk({tag, "_model_div1"}, 32'(mism1), 32'd0);
        chk({tag, "_model_div4"}, 32'(mism2), 32'd0);
        chk({tag, "_notick_toggle_div4"}, 32'(tog2), 32'd0);
        chk({tag, "_duty_div1"}, 32'(ptc1), 32'(n));
        chk({tag, "_duty_div4"}, 32'(ptc2), 32'(n / 4));
        chk({tag, "_period_div1"}, 32'(bad1), 32'd0);
        chk({tag, "_period_div4"}, 32'(bad2), 32'd0);
        chk({tag, "_fs_count_div1"}, 32'(nfs1), 32'(((n - 1) / 120) + 1));
        chk({tag, "_fs_count_div4"}, 32'(nfs2), 32'(((n - 1 - 3) / 480) + 1));
        chk({tag, "_fs_count_def"}, 32'(fsc0), 32'd1);
        if (n >= 1600) chk({tag, "_hsync_low_pixels"}, 32'(hslow0), 32'd96);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = mk(0,    0,   0, 1, 1, 1, 0, 0);
        tbl[1]  = mk(1,    0,   0, 1, 1, 1, 1, 1);
        tbl[2]  = mk(2,    1,   0, 1, 1, 1, 0, 0);
        tbl[3]  = mk(3,    1,   0, 1, 1, 1, 1, 0);
        tbl[4]  = mk(1279, 639, 0, 1, 1, 1, 1, 0);
        tbl[5]  = mk(1280, 640, 0, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1311, 655, 0, 1, 1, 0, 1, 0);
        tbl[7]  = mk(1312, 656, 0, 0, 1, 0, 0, 0);
        tbl[8]  = mk(1503, 751, 0, 0, 1, 0, 1, 0);
        tbl[9]  = mk(1504, 752, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(1599, 799, 0, 1, 1, 0, 1, 0);
        tbl[11] = mk(1600, 0,   1, 1, 1, 1, 0, 0);
        tbl[12] = mk(1601, 0,   1, 1, 1, 1, 1, 0);

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("reset_def", 32'(obs0), 32'(c_RST_PACK));
        chk("reset_div1", 32'(obs1), 32'(c_RST_PACK));
        chk("reset_div4", 32'(obs2), 32'(c_RST_PACK));

        run_phase(3001, "p1");
        chk("midframe_pos_def", 32'({x0, y0}), 32'({10'd700, 10'd1}));

        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_def", 32'(obs0), 32'(c_RST_PACK));
        chk("async_reset_div1", 32'(obs1), 32'(c_RST_PACK));
        chk("async_reset_div4", 32'(obs2), 32'(c_RST_PACK));
        repeat (2) @(posedge clk);

        run_phase(600, "p2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
